// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, redirect/stall
// selection and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        misalign_err
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic        r_mis;

  logic [31:0] w_pc_plus4;
  logic        w_redirect;
  logic [31:0] w_target;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_redirect = branch_taken | jump;

  // Branch comes from the older instruction in EX, so it wins.
  assign w_target = branch_taken ? branch_target
                                 : jump_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
    end else if (w_redirect) begin
      r_pc    <= {w_target[31:2], 2'b00};
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
      r_mis   <= |w_target[1:0];
    end else if (stall) begin
      r_mis   <= 1'b0;
    end else begin
      r_pc    <= w_pc_plus4;
      r_instr <= instr_in;
      r_pc4   <= w_pc_plus4;
      r_valid <= 1'b1;
      r_mis   <= 1'b0;
    end
  end

  assign pc            = r_pc;
  assign ifid_instr    = r_instr;
  assign ifid_pc_plus4 = r_pc4;
  assign ifid_valid    = r_valid;
  assign misalign_err  = r_mis;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes
// expected IF/ID state, a monitor pops and compares.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] instr_in;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        misalign_err;

  int   n_run;
  int   n_fail;
  exp_t sb[$];
  bit   done;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .instr_in     (instr_in),
    .pc           (pc),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid   (ifid_valid),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: word k holds 0x1000_0000 + k.
  assign instr_in = 32'h1000_0000 + {2'b00, pc[31:2]};

  function automatic logic [31:0] w(input int k);
    return 32'h1000_0000 + k;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".instr"}, ifid_instr, e.instr);
    chk({tag, ".pc4"}, ifid_pc_plus4, e.pc4);
    chk({tag, ".valid"}, {31'd0, ifid_valid},
        {31'd0, e.valid});
    chk({tag, ".pc"}, pc, e.pc);
    chk({tag, ".mis"}, {31'd0, misalign_err},
        {31'd0, e.mis});
  endtask

  // Called at a negedge: drive inputs, push what the
  // next posedge must produce, advance to next negedge.
  task automatic step(input logic s, input logic b,
                      input logic [31:0] bt,
                      input logic j,
                      input logic [31:0] jt,
                      input logic [31:0] ei,
                      input logic [31:0] ep4,
                      input logic ev,
                      input logic [31:0] epc,
                      input logic em);
    exp_t e;
    stall         = s;
    branch_taken  = b;
    branch_target = bt;
    jump          = j;
    jump_target   = jt;
    e.instr = ei;
    e.pc4   = ep4;
    e.valid = ev;
    e.pc    = epc;
    e.mis   = em;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input logic [31:0] ei,
                     input logic [31:0] ep4,
                     input logic [31:0] epc);
    step(0, 0, 0, 0, 0, ei, ep4, 1, epc, 0);
  endtask

  // Monitor: compares after every active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_all("edge", e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t rz;
    rz.instr = 32'd0;
    rz.pc4   = 32'd0;
    rz.valid = 1'b0;
    rz.pc    = 32'd0;
    rz.mis   = 1'b0;

    rst_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'd0;
    jump = 1'b0;
    jump_target = 32'd0;
    #3;
    chk_all("reset", rz);
    @(negedge clk);
    rst_n = 1'b1;

    run(w(0), 32'd4, 32'd4);
    run(w(1), 32'd8, 32'd8);
    run(w(2), 32'd12, 32'd12);
    repeat (3)
      step(1, 0, 0, 0, 0, w(2), 32'd12, 1, 32'd12, 0);
    run(w(3), 32'd16, 32'd16);
    run(w(4), 32'd20, 32'd20);

    step(0, 0, 0, 1, 32'h40, 0, 0, 0, 32'h40, 0);
    run(w(16), 32'h44, 32'h44);

    step(1, 1, 32'h20, 1, 32'h80, 0, 0, 0, 32'h20, 0);
    run(w(8), 32'h24, 32'h24);

    step(0, 1, 32'h22, 0, 0, 0, 0, 0, 32'h20, 1);
    run(w(8), 32'h24, 32'h24);

    step(0, 0, 0, 1, 32'h4A, 0, 0, 0, 32'h48, 1);
    run(w(18), 32'h4C, 32'h4C);

    step(0, 1, 32'h60, 1, 32'h81, 0, 0, 0, 32'h60, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h60, 0);
    run(w(24), 32'h64, 32'h64);

    step(0, 0, 0, 1, 32'hFFFF_FFFC,
         0, 0, 0, 32'hFFFF_FFFC, 0);
    run(w(32'h3FFF_FFFF), 32'd0, 32'd0);
    run(w(0), 32'd4, 32'd4);

    // Asynchronous reset with a misaligned jump pending.
    stall = 1'b0;
    jump = 1'b1;
    jump_target = 32'h0000_0103;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", rz);
    @(posedge clk);
    #1;
    chk_all("rst_hold", rz);
    @(negedge clk);
    rst_n = 1'b1;
    run(w(0), 32'd4, 32'd4);
    run(w(1), 32'd8, 32'd8);

    @(negedge clk);
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d left want 0",
               sb.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipeline: holds the program counter, drives it to the instruction memory's `PC` input, and captures the returned combinational `Instr` together with PC+4 into the IF/ID pipeline register. It applies redirects (taken branch from EX, jump from ID) and hazard-unit stalls, and inserts NOP bubbles on flush. It sits between the hazard/branch logic and the decode stage.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP_INSTR`, 32'h0000_0000, instruction word injected into IF/ID on flush/reset

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `stall`  in  1  hazard-unit load-use stall: hold PC and IF/ID
- `branch_taken`  in  1  taken branch resolved in EX
- `branch_target`  in  32  branch destination
- `jump`  in  1  jump decoded in ID
- `jump_target`  in  32  jump destination
- `instr_in`  in  32  instruction word from instruction memory for current `pc`
- `pc`  out  32  current fetch address, to instruction memory
- `ifid_instr`  out  32  registered instruction to decode
- `ifid_pc_plus4`  out  32  registered PC+4 of that instruction
- `ifid_valid`  out  1  1 = real instruction, 0 = bubble
- `misalign_err`  out  1  one-cycle pulse: accepted redirect target had nonzero bits [1:0]

## Operation
- Memory is word-addressed by `pc[31:2]`; `instr_in` is valid combinationally in the same cycle `pc` is driven. No delay slots.
- Next-state selection each rising edge, highest priority first:
  1. `branch_taken`: `pc` <= {branch_target[31:2],2'b00}; IF/ID <= bubble (`NOP_INSTR`, pc_plus4 0, valid 0).
  2. `jump`: `pc` <= {jump_target[31:2],2'b00}; IF/ID <= bubble.
  3. `stall`: `pc` and all IF/ID outputs hold.
  4. otherwise: `pc` <= pc+4; `ifid_instr` <= instr_in; `ifid_pc_plus4` <= pc+4; `ifid_valid` <= 1.
- Branch beats jump when both are set (EX instruction is older). A redirect beats stall.
- `misalign_err` <= 1 for exactly the cycle after an accepted redirect whose target[1:0] != 0, else 0. A jump ignored because of a simultaneous branch never flags.
- PC+4 is modulo 2^32: `pc` 32'hFFFF_FFFC advances to 32'h0000_0000 with no error.
- The fetch stage never decodes; a bubble is identified only by `ifid_valid`=0.

## Timing
- Reset (asynchronous assertion, any time): `pc`=RESET_PC, `ifid_instr`=NOP_INSTR, `ifid_pc_plus4`=0, `ifid_valid`=0, `misalign_err`=0. Reset mid-stall or mid-redirect discards the pending update.
- First rising edge after `rst_n` deasserts: IF/ID captures the word at RESET_PC, `ifid_valid`=1, `pc`=RESET_PC+4.
- Fetch-to-IF/ID latency: 1 cycle. Redirect penalty: the redirect cycle yields one bubble; the target instruction reaches IF/ID on the following edge.
- Stall held N cycles: `pc` and IF/ID frozen N cycles; the held instruction is not lost or duplicated.
- All outputs are registered, except that `pc` is itself a register driving the combinational memory path.

## Test plan
- Reset then 4 free-running cycles, memory word k = 32'h1000_0000+k -> IF/ID shows words 0,1,2,3 with pc_plus4 4,8,12,16, valid=1; `pc`=16.
- `stall`=1 for 3 cycles while `ifid_instr`=word 2 -> `pc` stays 12, IF/ID holds word 2; after release, word 3 arrives next edge.
- `jump`=1, target 32'h40 -> next edge `pc`=0x40, valid=0; following edge `ifid_instr`=word 16, pc_plus4 0x44.
- `branch_taken`=1 (target 0x20) with `jump`=1 (target 0x80) and `stall`=1 together -> `pc`=0x20, bubble, `misalign_err`=0.
- `branch_target`=32'h0000_0022 -> `pc`=0x20, `misalign_err` high for exactly one cycle.
- Force `pc` to 32'hFFFF_FFFC via jump, run 1 cycle -> `pc`=0, `ifid_pc_plus4`=0; assert `rst_n`=0 mid-cycle -> all outputs reach reset values immediately, without waiting for a clock edge.
